// File: rtl/led_pwm_multi.sv
// ============================================================================
// led_pwm_multi
// ----------------------------------------------------------------------------
// Multi-channel LED PWM driver. All channels share one free-running period
// counter, one step divider and one triangle generator. Breathe and blink
// channels therefore stay phase-locked to each other.
//
// Each channel has a shadow (duty, mode) register that is written by the
// configuration port, and an active copy that drives the comparator. Shadows
// are copied to the active registers only at the end of a PWM period, so a
// duty change never produces a truncated or stretched pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   en           global output enable (low forces every pwm_out bit to 0)
//   cfg_we       one-cycle configuration write strobe
//   cfg_ch       channel index for the write (out-of-range indices ignored)
//   cfg_duty     duty level (static/blink) or peak level (breathe)
//   cfg_mode     00 off, 01 static, 10 breathe, 11 blink
//   step_div     breathe/blink step period minus one, in clk cycles
//   pwm_out      registered PWM outputs, bit i = channel i
//   period_start registered pulse aligned with the first pwm_out cycle of a period
//   tri_level    current shared triangle value
// ============================================================================
module led_pwm_multi #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int DIV_W    = 12,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_duty,
    input  logic [1:0]          cfg_mode,
    input  logic [DIV_W-1:0]    step_div,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start,
    output logic [WIDTH-1:0]    tri_level
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_BLINK   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // ------------------------------------------------------------------------
    // Period counter: free-running, wraps MAX -> 0, ignores en.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_cnt;
    logic             w_cnt_max;
    logic             w_cnt_zero;

    assign w_cnt_max  = (r_cnt == MAX_VAL);
    assign w_cnt_zero = (r_cnt == ZERO_VAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= ZERO_VAL;
        end else begin
            r_cnt <= r_cnt + ONE_VAL;
        end
    end

    // ------------------------------------------------------------------------
    // Step divider. A tick normally fires when the count reaches step_div.
    // If step_div is lowered below the running count, the equality is missed;
    // the all-ones term lets the counter run to its top, tick and wrap so the
    // divider always recovers without a reset.
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;

    assign w_tick = (r_div_cnt == step_div) || (&r_div_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Triangle generator: two-process state machine on the direction.
    // The turn-around steps straight to MAX-1 / 1 so neither extreme is held
    // for two ticks, giving a full cycle of 2*MAX ticks.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_tri;
    logic [WIDTH-1:0] w_tri_next;
    dir_e             r_dir;
    dir_e             w_dir_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tri <= ZERO_VAL;
            r_dir <= DIR_UP;
        end else begin
            r_tri <= w_tri_next;
            r_dir <= w_dir_next;
        end
    end

    always_comb begin
        w_tri_next = r_tri;
        w_dir_next = r_dir;
        if (w_tick) begin
            unique case (r_dir)
                DIR_UP: begin
                    if (r_tri == MAX_VAL) begin
                        w_dir_next = DIR_DOWN;
                        w_tri_next = MAX_VAL - ONE_VAL;
                    end else begin
                        w_tri_next = r_tri + ONE_VAL;
                    end
                end
                DIR_DOWN: begin
                    if (r_tri == ZERO_VAL) begin
                        w_dir_next = DIR_UP;
                        w_tri_next = ONE_VAL;
                    end else begin
                        w_tri_next = r_tri - ONE_VAL;
                    end
                end
                default: begin
                    w_dir_next = DIR_UP;
                    w_tri_next = ZERO_VAL;
                end
            endcase
        end
    end

    assign tri_level = r_tri;

    // ------------------------------------------------------------------------
    // Configuration decode. The index is widened by one bit so the range test
    // also works when CHANNELS is an exact power of two.
    // ------------------------------------------------------------------------
    logic w_ch_valid;
    assign w_ch_valid = ({1'b0, cfg_ch} < CHANNELS[CH_W:0]);

    // ------------------------------------------------------------------------
    // Per-channel shadow/active registers, level select and comparator.
    // ------------------------------------------------------------------------
    logic [CHANNELS-1:0] w_cmp;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [WIDTH-1:0] r_sh_duty;
        mode_e            r_sh_mode;
        logic [WIDTH-1:0] r_ac_duty;
        mode_e            r_ac_mode;
        logic             w_sel;
        logic [WIDTH-1:0] w_level;
        logic             w_hit;

        assign w_sel = cfg_we && w_ch_valid && (cfg_ch == CH_W'(gi));

        // Non-blocking assignment makes the active copy take the pre-edge
        // shadow value, so a write landing on the MAX edge waits one period.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sh_duty <= ZERO_VAL;
                r_sh_mode <= MODE_OFF;
                r_ac_duty <= ZERO_VAL;
                r_ac_mode <= MODE_OFF;
            end else begin
                if (w_sel) begin
                    r_sh_duty <= cfg_duty;
                    r_sh_mode <= mode_e'(cfg_mode);
                end
                if (w_cnt_max) begin
                    r_ac_duty <= r_sh_duty;
                    r_ac_mode <= r_sh_mode;
                end
            end
        end

        always_comb begin
            w_level = ZERO_VAL;
            unique case (r_ac_mode)
                MODE_OFF:     w_level = ZERO_VAL;
                MODE_STATIC:  w_level = r_ac_duty;
                MODE_BREATHE: w_level = (r_tri < r_ac_duty) ? r_tri : r_ac_duty;
                MODE_BLINK:   w_level = (r_dir == DIR_UP) ? r_ac_duty : ZERO_VAL;
                default:      w_level = ZERO_VAL;
            endcase
        end

        // MAX is forced high: "level > counter" alone would drop the output
        // for the single cycle where the counter itself is MAX.
        always_comb begin
            w_hit = 1'b0;
            if (w_level == ZERO_VAL) begin
                w_hit = 1'b0;
            end else if (w_level == MAX_VAL) begin
                w_hit = 1'b1;
            end else begin
                w_hit = (w_level > r_cnt);
            end
        end

        assign w_cmp[gi] = w_hit;
    end

    // ------------------------------------------------------------------------
    // Output registers. Both are computed from the same counter value, so the
    // period_start pulse lines up with the pwm_out cycle for counter 0.
    // ------------------------------------------------------------------------
    logic [CHANNELS-1:0] r_pwm;
    logic                r_period_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_pwm          <= en ? w_cmp : '0;
            r_period_start <= w_cnt_zero;
        end
    end

    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_led_pwm_multi.sv
// ============================================================================
// tb_led_pwm_multi
// ----------------------------------------------------------------------------
// Self-checking bench for led_pwm_multi (WIDTH=4, CHANNELS=4, DIV_W=4).
// A reference model advances once per clock edge; the triangle is computed
// in closed form from the number of ticks since reset. Every cycle the DUT
// outputs are compared with the model, and table entries and hand-written
// sequences add targeted checks for the corner cases.
// ============================================================================
module tb_led_pwm_multi;

    localparam int W    = 4;
    localparam int NCH  = 4;
    localparam int DW   = 4;
    localparam int MAXV = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [W-1:0]   cfg_duty;
    logic [1:0]     cfg_mode;
    logic [DW-1:0]  step_div;
    logic [NCH-1:0] pwm_out;
    logic           period_start;
    logic [W-1:0]   tri_level;

    led_pwm_multi #(.WIDTH(W), .CHANNELS(NCH), .DIV_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_duty     (cfg_duty),
        .cfg_mode     (cfg_mode),
        .step_div     (step_div),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .tri_level    (tri_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model state ----------------
    int         m_cnt   = 0;
    int         m_phase = 0;   // cycles since the last divider tick
    int         m_ticks = 0;   // ticks since reset
    int         m_sh_duty [NCH];
    int         m_sh_mode [NCH];
    int         m_ac_duty [NCH];
    int         m_ac_mode [NCH];
    logic [NCH-1:0] m_pwm = '0;
    logic           m_ps  = 1'b0;

    // Triangle after t ticks: 0,1..15,14..1,0,1.. with a 30-tick cycle.
    function automatic int tri_of(input int t);
        int p;
        p = t % (2 * MAXV);
        return (p <= MAXV) ? p : (2 * MAXV - p);
    endfunction

    // Rising from the reset state, or on ticks 1..15 of each cycle.
    function automatic bit up_of(input int t);
        int p;
        p = t % (2 * MAXV);
        return (t == 0) || (p >= 1 && p <= MAXV);
    endfunction

    function automatic int level_of(input int ch);
        int tv;
        tv = tri_of(m_ticks);
        case (m_ac_mode[ch])
            1:       return m_ac_duty[ch];
            2:       return (tv < m_ac_duty[ch]) ? tv : m_ac_duty[ch];
            3:       return up_of(m_ticks) ? m_ac_duty[ch] : 0;
            default: return 0;
        endcase
    endfunction

    function automatic bit out_of(input int ch);
        int lv;
        lv = level_of(ch);
        if (lv == 0)    return 1'b0;
        if (lv == MAXV) return 1'b1;
        return lv > m_cnt;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_cnt = 0; m_phase = 0; m_ticks = 0;
            for (int i = 0; i < NCH; i++) begin
                m_sh_duty[i] = 0; m_sh_mode[i] = 0;
                m_ac_duty[i] = 0; m_ac_mode[i] = 0;
            end
            m_pwm = '0;
            m_ps  = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) m_pwm[i] = en && out_of(i);
            m_ps = (m_cnt == 0);
            if (m_cnt == MAXV) begin
                for (int i = 0; i < NCH; i++) begin
                    m_ac_duty[i] = m_sh_duty[i];
                    m_ac_mode[i] = m_sh_mode[i];
                end
            end
            if (cfg_we) begin
                m_sh_duty[cfg_ch] = int'(cfg_duty);
                m_sh_mode[cfg_ch] = int'(cfg_mode);
            end
            if (m_phase == int'(step_div) || m_phase == (1 << DW) - 1) begin
                m_phase = 0;
                m_ticks++;
            end else begin
                m_phase++;
            end
            m_cnt = (m_cnt + 1) % (MAXV + 1);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: model advances on the edge, DUT sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("pwm_out", 32'(pwm_out), 32'(m_pwm));
        check("period_start", 32'(period_start), 32'(m_ps));
        check("tri_level", 32'(tri_level), 32'(tri_of(m_ticks)));
        cfg_we = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int k = 0; k < cycles; k++) step();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int mode, input int duty);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_mode = 2'(mode);
        cfg_duty = W'(duty);
        step();
    endtask

    // Run until the edge that copies shadows into the active registers has
    // passed; afterwards the next edge produces the counter-0 output.
    task automatic run_to_load();
        for (int k = 0; k < 20 && m_cnt != MAXV; k++) step();
        step();
    endtask

    typedef struct {
        int duty;
        int exp_highs;
        int exp_first;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int highs;
        int pulses;
        int drops;
        int seen_high;
        int waited;

        tbl[0] = '{duty: 0,  exp_highs: 0,  exp_first: 0};
        tbl[1] = '{duty: 1,  exp_highs: 1,  exp_first: 1};
        tbl[2] = '{duty: 5,  exp_highs: 5,  exp_first: 1};
        tbl[3] = '{duty: 9,  exp_highs: 9,  exp_first: 1};
        tbl[4] = '{duty: 14, exp_highs: 14, exp_first: 1};
        tbl[5] = '{duty: 15, exp_highs: 16, exp_first: 1};

        rst = 1'b1; en = 1'b1; cfg_we = 1'b0; cfg_ch = '0;
        cfg_duty = '0; cfg_mode = '0; step_div = 4'd0;

        // ---- reset state and idle behaviour ----
        do_reset(3);
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_ps", 32'(period_start), 32'd0);
        check("reset_tri", 32'(tri_level), 32'd0);
        step();
        check("ps_first_after_rst", 32'(period_start), 32'd1);
        pulses = 1; highs = 0;
        for (int k = 0; k < 39; k++) begin
            step();
            pulses += int'(period_start);
            highs  += int'(pwm_out != 0);
        end
        check("idle_ps_pulses", 32'(pulses), 32'd3);
        check("idle_pwm_highs", 32'(highs), 32'd0);
        $display("seq idle: period_start pulses=%0d pwm_high_cycles=%0d", pulses, highs);

        // ---- table: static duty on channel 0 ----
        for (int v = 0; v < 6; v++) begin
            cfg_write(0, 1, tbl[v].duty);
            run_to_load();
            step();
            check($sformatf("first_aligned_d%0d", tbl[v].duty), 32'(pwm_out[0]), 32'(tbl[v].exp_first));
            check($sformatf("first_ps_d%0d", tbl[v].duty), 32'(period_start), 32'd1);
            highs = int'(pwm_out[0]);
            for (int k = 1; k < 16; k++) begin
                step();
                highs += int'(pwm_out[0]);
            end
            check($sformatf("highs_d%0d", tbl[v].duty), 32'(highs), 32'(tbl[v].exp_highs));
            $display("vec %0d: duty=%0d highs=%0d", v, tbl[v].duty, highs);
        end

        // ---- ch1 static 0 then 15: no gap once it turns on ----
        cfg_write(1, 1, 0);
        run_to_load();
        cfg_write(1, 1, 15);
        seen_high = 0; drops = 0;
        for (int k = 0; k < 48; k++) begin
            step();
            if (pwm_out[1]) seen_high = 1;
            else if (seen_high != 0) drops++;
        end
        check("ch1_full_seen", 32'(seen_high), 32'd1);
        check("ch1_full_gaps", 32'(drops), 32'd0);
        $display("seq ch1 0->15: gaps=%0d", drops);

        // ---- ch2 write on the counter==MAX edge takes one extra period ----
        for (int k = 0; k < 20 && m_cnt != MAXV; k++) step();
        cfg_write(2, 1, 9);
        highs = 0;
        for (int k = 0; k < 16; k++) begin step(); highs += int'(pwm_out[2]); end
        check("ch2_old_period", 32'(highs), 32'd0);
        highs = 0;
        for (int k = 0; k < 16; k++) begin step(); highs += int'(pwm_out[2]); end
        check("ch2_new_period", 32'(highs), 32'd9);
        $display("seq ch2 late write: second-period highs=%0d", highs);

        // ---- breathe, step_div=0 ----
        step_div = 4'd0;
        do_reset(2);
        cfg_write(3, 2, 8);
        cfg_write(0, 1, 6);
        highs = 0;
        for (int k = 0; k < 70; k++) begin
            step();
            if (int'(tri_level) > highs) highs = int'(tri_level);
        end
        check("breathe_tri_peak", 32'(highs), 32'd15);
        $display("seq breathe: tri peak=%0d", highs);

        // ---- en low mid-period, then reset mid-breath ----
        for (int k = 0; k < 5; k++) step();
        en = 1'b0;
        step();
        check("en_low_pwm", 32'(pwm_out), 32'd0);
        for (int k = 0; k < 9; k++) step();
        en = 1'b1;
        for (int k = 0; k < 20; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_tri", 32'(tri_level), 32'd0);
        check("rst_mid_pwm", 32'(pwm_out), 32'd0);
        highs = 0;
        for (int k = 0; k < 40; k++) begin step(); highs += int'(pwm_out != 0); end
        check("rst_all_off", 32'(highs), 32'd0);
        $display("seq en/rst: pwm highs after rst=%0d", highs);

        // ---- divider recovery when step_div drops below the count ----
        step_div = 4'd10;
        do_reset(2);
        for (int k = 0; k < 8; k++) step();
        step_div = 4'd2;
        waited = 0;
        for (int k = 0; k < 40 && tri_level == 0; k++) begin step(); waited++; end
        check("div_wrap_delay", 32'(waited), 32'd8);
        $display("seq step_div drop: first tick after %0d cycles", waited);

        // ---- randomized traffic against the model ----
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) step_div = DW'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                cfg_we   = 1'b1;
                cfg_ch   = 2'($urandom_range(0, 3));
                cfg_mode = 2'($urandom_range(0, 3));
                cfg_duty = W'($urandom_range(0, 15));
            end
            step();
        end
        rst = 1'b0;
        $display("seq random: 3000 cycles done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
